// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Registered instruction-decode pipeline stage for the 8-bit RISC core.
// Classifies each instruction (R / I / J / illegal), extracts the function,
// immediate and jump-target fields, and hands the decoded bundle downstream
// over a valid/ready handshake. A main register plus one skid entry let
// in_ready be driven straight from a flop. A saturating counter tallies
// accepted illegal opcodes.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   flush                synchronous discard of both buffered entries
//   in_valid/in_ready    upstream handshake (in_ready is registered)
//   in_instr             instruction word
//   out_valid/out_ready  downstream handshake
//   out_opcode, out_fn   opcode and function fields
//   out_imm              immediate, sign- or zero-extended to DATA_W
//   out_jaddr            jump target field
//   out_is_r/i/j, out_illegal  one-hot instruction class
//   cnt_clr, ill_count   clear and value of the illegal-instruction counter
// ---------------------------------------------------------------------------
module decode_stage #(
   parameter int INSTR_W  = 16,
   parameter int DATA_W   = 8,
   parameter int IMM_W    = 7,
   parameter int SIGN_EXT = 1,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   in_instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2:0]           out_opcode,
   output logic [1:0]           out_fn,
   output logic [DATA_W-1:0]    out_imm,
   output logic [INSTR_W-4:0]   out_jaddr,
   output logic                 out_is_r,
   output logic                 out_is_i,
   output logic                 out_is_j,
   output logic                 out_illegal,
   input  logic                 cnt_clr,
   output logic [CNT_W-1:0]     ill_count
);

   localparam int JADDR_W = INSTR_W - 3;

   typedef struct packed {
      logic [2:0]         opcode;
      logic [1:0]         fn;
      logic [DATA_W-1:0]  imm;
      logic [JADDR_W-1:0] jaddr;
      logic               is_r;
      logic               is_i;
      logic               is_j;
      logic               illegal;
   } bundle_t;

   bundle_t               dec_bundle;
   logic [DATA_W-1:0]     imm_ext;

   bundle_t               main_reg, main_next;
   bundle_t               skid_reg, skid_next;
   logic                  main_valid_reg, main_valid_next;
   logic                  skid_valid_reg, skid_valid_next;
   logic                  in_ready_reg;
   logic [CNT_W-1:0]      ill_count_reg, ill_count_next;

   logic                  accept;
   logic                  drain;

   // Immediate extension: low IMM_W bits come from the field, the rest are
   // copies of the field's top bit (sign) or zero.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_imm
         if (gi < IMM_W) begin : g_field
            assign imm_ext[gi] = in_instr[INSTR_W-3-IMM_W+gi];
         end else if (SIGN_EXT != 0) begin : g_sign
            assign imm_ext[gi] = in_instr[INSTR_W-4];
         end else begin : g_zero
            assign imm_ext[gi] = 1'b0;
         end
      end
   endgenerate

   // Combinational decode of the incoming word.
   always_comb begin
      dec_bundle         = '0;
      dec_bundle.opcode  = in_instr[INSTR_W-1 -: 3];
      dec_bundle.fn      = in_instr[INSTR_W-4 -: 2];
      dec_bundle.imm     = imm_ext;
      dec_bundle.jaddr   = in_instr[INSTR_W-4:0];
      case (in_instr[INSTR_W-1 -: 3])
         3'b000:                         dec_bundle.is_r    = 1'b1;
         3'b001, 3'b010, 3'b011, 3'b100: dec_bundle.is_i    = 1'b1;
         3'b101:                         dec_bundle.is_j    = 1'b1;
         default:                        dec_bundle.illegal = 1'b1;
      endcase
   end

   // in_ready_reg mirrors "skid empty", so an accept can never collide with
   // an occupied skid entry.
   assign accept = in_valid && in_ready_reg && !flush;
   assign drain  = main_valid_reg && out_ready;

   always_comb begin
      main_next       = main_reg;
      main_valid_next = main_valid_reg;
      skid_next       = skid_reg;
      skid_valid_next = skid_valid_reg;
      if (flush) begin
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else if (!main_valid_reg || drain) begin
         // Main is free this cycle: refill from skid first to keep order.
         if (skid_valid_reg) begin
            main_next       = skid_reg;
            main_valid_next = 1'b1;
            skid_valid_next = 1'b0;
         end else if (accept) begin
            main_next       = dec_bundle;
            main_valid_next = 1'b1;
         end else begin
            main_valid_next = 1'b0;
         end
      end else if (accept) begin
         // Main stalled: park the new instruction in skid.
         skid_next       = dec_bundle;
         skid_valid_next = 1'b1;
      end
   end

   always_comb begin
      ill_count_next = ill_count_reg;
      if (cnt_clr) begin
         ill_count_next = '0;
      end else if (accept && dec_bundle.illegal && (ill_count_reg != {CNT_W{1'b1}})) begin
         ill_count_next = ill_count_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_reg       <= '0;
         skid_reg       <= '0;
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         in_ready_reg   <= 1'b1;
         ill_count_reg  <= '0;
      end else begin
         main_reg       <= main_next;
         skid_reg       <= skid_next;
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         in_ready_reg   <= !skid_valid_next;
         ill_count_reg  <= ill_count_next;
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = main_valid_reg;
   assign out_opcode  = main_reg.opcode;
   assign out_fn      = main_reg.fn;
   assign out_imm     = main_reg.imm;
   assign out_jaddr   = main_reg.jaddr;
   assign out_is_r    = main_reg.is_r;
   assign out_is_i    = main_reg.is_i;
   assign out_is_j    = main_reg.is_j;
   assign out_illegal = main_reg.illegal;
   assign ill_count   = ill_count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed self-checking bench for decode_stage. Three instances share the
// same stimulus: default parameters, a zero-extending variant and a 2-bit
// counter variant.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        out_ready;
   logic        cnt_clr;

   logic        in_ready, out_valid, out_is_r, out_is_i, out_is_j, out_illegal;
   logic [2:0]  out_opcode;
   logic [1:0]  out_fn;
   logic [7:0]  out_imm;
   logic [12:0] out_jaddr;
   logic [7:0]  ill_count;

   logic        zx_in_ready, zx_out_valid, zx_is_r, zx_is_i, zx_is_j, zx_illegal;
   logic [2:0]  zx_opcode;
   logic [1:0]  zx_fn;
   logic [7:0]  zx_imm;
   logic [12:0] zx_jaddr;
   logic [7:0]  zx_ill_count;

   logic        c2_in_ready, c2_out_valid, c2_is_r, c2_is_i, c2_is_j, c2_illegal;
   logic [2:0]  c2_opcode;
   logic [1:0]  c2_fn;
   logic [7:0]  c2_imm;
   logic [12:0] c2_jaddr;
   logic [1:0]  c2_ill_count;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_fn(out_fn), .out_imm(out_imm), .out_jaddr(out_jaddr),
      .out_is_r(out_is_r), .out_is_i(out_is_i), .out_is_j(out_is_j),
      .out_illegal(out_illegal), .cnt_clr(cnt_clr), .ill_count(ill_count)
   );

   decode_stage #(.SIGN_EXT(0)) dut_zx (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(zx_in_ready),
      .in_instr(in_instr), .out_valid(zx_out_valid), .out_ready(out_ready),
      .out_opcode(zx_opcode), .out_fn(zx_fn), .out_imm(zx_imm), .out_jaddr(zx_jaddr),
      .out_is_r(zx_is_r), .out_is_i(zx_is_i), .out_is_j(zx_is_j),
      .out_illegal(zx_illegal), .cnt_clr(cnt_clr), .ill_count(zx_ill_count)
   );

   decode_stage #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c2_in_ready),
      .in_instr(in_instr), .out_valid(c2_out_valid), .out_ready(out_ready),
      .out_opcode(c2_opcode), .out_fn(c2_fn), .out_imm(c2_imm), .out_jaddr(c2_jaddr),
      .out_is_r(c2_is_r), .out_is_i(c2_is_i), .out_is_j(c2_is_j),
      .out_illegal(c2_illegal), .cnt_clr(cnt_clr), .ill_count(c2_ill_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
      checks++; if (ill_count !== 8'd0) $display("FAIL reset_ill_count: got %0d want 0", ill_count); else passes++;
      checks++; if ({out_is_r, out_is_i, out_is_j, out_illegal} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {out_is_r, out_is_i, out_is_j, out_illegal}); else passes++;
      checks++; if ({out_opcode, out_fn, out_imm, out_jaddr} !== 26'd0)
         $display("FAIL reset_fields: got %h want 0", {out_opcode, out_fn, out_imm, out_jaddr}); else passes++;
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b want 0", out_valid); else passes++;
      $display("reset: done");
   endtask

   task automatic test_rtype();
      in_valid = 1'b1; in_instr = 16'h0800; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL r_valid: got %b want 1", out_valid); else passes++;
      checks++; if (out_opcode !== 3'b000) $display("FAIL r_opcode: got %b want 000", out_opcode); else passes++;
      checks++; if (out_fn !== 2'b01) $display("FAIL r_fn: got %b want 01", out_fn); else passes++;
      checks++; if (out_imm !== 8'h20) $display("FAIL r_imm: got %h want 20", out_imm); else passes++;
      checks++; if ({out_is_r, out_is_i, out_is_j, out_illegal} !== 4'b1000)
         $display("FAIL r_flags: got %b want 1000", {out_is_r, out_is_i, out_is_j, out_illegal}); else passes++;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL r_drained: got %b want 0", out_valid); else passes++;
      $display("rtype: instr 0800 opcode %b fn %b imm %h", out_opcode, out_fn, out_imm);
   endtask

   task automatic test_itype();
      in_valid = 1'b1; in_instr = 16'h3FC0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if ({out_is_r, out_is_i, out_is_j, out_illegal} !== 4'b0100)
         $display("FAIL i_flags: got %b want 0100", {out_is_r, out_is_i, out_is_j, out_illegal}); else passes++;
      checks++; if (out_opcode !== 3'b001) $display("FAIL i_opcode: got %b want 001", out_opcode); else passes++;
      checks++; if (out_imm !== 8'hFF) $display("FAIL i_imm_sext: got %h want ff", out_imm); else passes++;
      checks++; if (zx_imm !== 8'h7F) $display("FAIL i_imm_zext: got %h want 7f", zx_imm); else passes++;
      $display("itype: instr 3fc0 imm sext %h zext %h", out_imm, zx_imm);
      tick();
   endtask

   task automatic test_jtype();
      in_valid = 1'b1; in_instr = 16'hA123; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if ({out_is_r, out_is_i, out_is_j, out_illegal} !== 4'b0010)
         $display("FAIL j_flags: got %b want 0010", {out_is_r, out_is_i, out_is_j, out_illegal}); else passes++;
      checks++; if (out_jaddr !== 13'h0123) $display("FAIL j_jaddr: got %h want 0123", out_jaddr); else passes++;
      $display("jtype: instr a123 jaddr %h", out_jaddr);
      tick();
   endtask

   task automatic test_illegal();
      in_valid = 1'b1; in_instr = 16'hE000; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if ({out_is_r, out_is_i, out_is_j, out_illegal} !== 4'b0001)
            $display("FAIL ill_flags_%0d: got %b want 0001", i, {out_is_r, out_is_i, out_is_j, out_illegal}); else passes++;
         checks++; if (in_ready !== 1'b1) $display("FAIL ill_b2b_ready_%0d: got %b want 1", i, in_ready); else passes++;
         if (i == 3) begin
            checks++; if (ill_count !== 8'd4) $display("FAIL ill_count4: got %0d want 4", ill_count); else passes++;
         end
         $display("illegal: accept %0d ill_count %0d c2 %0d", i, ill_count, c2_ill_count);
      end
      checks++; if (ill_count !== 8'd5) $display("FAIL ill_count5: got %0d want 5", ill_count); else passes++;
      checks++; if (c2_ill_count !== 2'd3) $display("FAIL ill_sat: got %0d want 3", c2_ill_count); else passes++;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0; in_valid = 1'b0;
      checks++; if (ill_count !== 8'd0) $display("FAIL ill_clr: got %0d want 0", ill_count); else passes++;
      checks++; if (c2_ill_count !== 2'd0) $display("FAIL ill_clr_c2: got %0d want 0", c2_ill_count); else passes++;
      $display("illegal: after clr ill_count %0d", ill_count);
      tick();
   endtask

   task automatic test_backpressure();
      logic [15:0] src [4];
      logic        exp_rdy [8];
      int          src_idx = 0;
      int          dlv_idx = 0;
      src[0] = 16'h0800; src[1] = 16'h2040; src[2] = 16'hA001; src[3] = 16'h0000;
      exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b0;
      exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b1; exp_rdy[6] = 1'b1; exp_rdy[7] = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         out_ready = !(cyc >= 1 && cyc <= 3);
         in_valid  = (src_idx < 4);
         in_instr  = (src_idx < 4) ? src[src_idx] : 16'h0000;
         if (cyc < 8) begin
            checks++; if (in_ready !== exp_rdy[cyc])
               $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, exp_rdy[cyc]); else passes++;
         end
         if (cyc >= 1 && cyc <= 4) begin
            checks++; if (!(out_valid === 1'b1 && {out_opcode, out_jaddr} === 16'h0800))
               $display("FAIL bp_hold_c%0d: got valid %b instr %h want 1 0800", cyc, out_valid, {out_opcode, out_jaddr}); else passes++;
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (dlv_idx >= 4) $display("FAIL bp_extra: got extra delivery %h want none", {out_opcode, out_jaddr});
            else if ({out_opcode, out_jaddr} !== src[dlv_idx])
               $display("FAIL bp_order_%0d: got %h want %h", dlv_idx, {out_opcode, out_jaddr}, src[dlv_idx]);
            else passes++;
            $display("backpressure: cycle %0d delivered %h", cyc, {out_opcode, out_jaddr});
            dlv_idx++;
         end
         if (in_valid && in_ready) src_idx++;
         tick();
      end
      in_valid = 1'b0;
      checks++; if (dlv_idx !== 4) $display("FAIL bp_count: got %0d want 4", dlv_idx); else passes++;
      checks++; if (src_idx !== 4) $display("FAIL bp_accepts: got %0d want 4", src_idx); else passes++;
   endtask

   task automatic test_flush();
      // Both entries full, flush together with an illegal offer.
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0800;
      tick();
      in_instr = 16'h2040;
      tick();
      checks++; if (in_ready !== 1'b0) $display("FAIL fl_full: got %b want 0", in_ready); else passes++;
      flush = 1'b1; in_instr = 16'hE000;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL fl_valid: got %b want 0", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL fl_ready: got %b want 1", in_ready); else passes++;
      checks++; if (ill_count !== 8'd0) $display("FAIL fl_count: got %0d want 0", ill_count); else passes++;
      out_ready = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL fl_nothing: got %b want 0", out_valid); else passes++;
      $display("flush: both-full flush out_valid %b in_ready %b", out_valid, in_ready);
      // Main only full: the flush-cycle illegal would be accepted but must be discarded.
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0800;
      tick();
      flush = 1'b1; in_instr = 16'hE000;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL fl2_valid: got %b want 0", out_valid); else passes++;
      checks++; if (ill_count !== 8'd0) $display("FAIL fl2_count: got %0d want 0", ill_count); else passes++;
      $display("flush: accept-cycle flush ill_count %0d", ill_count);
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hE000;
      tick();
      in_instr = 16'hA123;
      tick();
      in_valid = 1'b0;
      checks++; if (ill_count !== 8'd1) $display("FAIL ar_pre_count: got %0d want 1", ill_count); else passes++;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL ar_ready: got %b want 1", in_ready); else passes++;
      checks++; if (ill_count !== 8'd0) $display("FAIL ar_count: got %0d want 0", ill_count); else passes++;
      checks++; if ({out_is_r, out_is_i, out_is_j, out_illegal} !== 4'b0000)
         $display("FAIL ar_flags: got %b want 0000", {out_is_r, out_is_i, out_is_j, out_illegal}); else passes++;
      checks++; if ({out_opcode, out_fn, out_imm, out_jaddr} !== 26'd0)
         $display("FAIL ar_fields: got %h want 0", {out_opcode, out_fn, out_imm, out_jaddr}); else passes++;
      #2;
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL ar_after: got %b want 0", out_valid); else passes++;
      $display("async_reset: out_valid %b in_ready %b ill_count %0d", out_valid, in_ready, ill_count);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0000;
      out_ready = 1'b0; cnt_clr = 1'b0;
      #1;
      rst = 1'b1;
      tick();
      tick();
      test_reset();
      test_rtype();
      test_itype();
      test_jtype();
      test_illegal();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
